// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, opcode
// constants, ALU operation classes and small decode helpers.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I_ALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Every hop into FETCH is an instruction boundary where a halt request is honoured.
    function automatic state_t boundary_target(input logic halt);
        return halt ? S_IDLE : S_FETCH;
    endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running performance counters for busy cycles and retired
// instructions; both wrap naturally at 2^32.
module mc_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_cycle,
    input  logic        count_instr,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (count_cycle) cycle_cnt <= cycle_cnt + 32'd1;
            if (count_instr) instr_cnt <= instr_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RISC-V style control FSM with memory-wait timeout and traps.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_control
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic        busy,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX - 1);

    state_t            cur_state;
    logic [WAIT_W-1:0] wait_cnt;

    assign state = cur_state;

    // State, wait counter and sticky trap causes; a ready strobe in the
    // final allowed wait cycle still completes the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (start) begin
                        cur_state <= boundary_target(halt);
                        wait_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        cur_state <= S_DECODE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        cur_state <= S_TRAP;
                        timeout   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        cur_state <= S_EXEC;
                    end else begin
                        cur_state <= S_TRAP;
                        illegal   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R, OP_I_ALU: cur_state <= S_WB;
                        OP_LOAD, OP_STORE: begin
                            cur_state <= S_MEM;
                            wait_cnt  <= '0;
                        end
                        OP_BRANCH: begin
                            cur_state <= boundary_target(halt);
                            wait_cnt  <= '0;
                        end
                        default: begin
                            cur_state <= S_TRAP;
                            illegal   <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cur_state <= (opcode == OP_LOAD) ? S_WB : boundary_target(halt);
                        wait_cnt  <= '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        cur_state <= S_TRAP;
                        timeout   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    cur_state <= boundary_target(halt);
                    wait_cnt  <= '0;
                end
                default: cur_state <= S_TRAP;
            endcase
        end
    end

    // Datapath controls follow the state register, opcode and the ALU/memory
    // completion inputs; start and halt only steer transitions.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALU_ADD;
        busy       = (cur_state != S_IDLE);
        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R:     alu_op = ALU_FUNCT;
                    OP_I_ALU: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: alu_src = 1'b1;
                    OP_BRANCH: begin
                        alu_op   = ALU_SUB;
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_src = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    pc_write  = dmem_ready;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    mc_perf_cnt u_perf_cnt (
        .clk         (clk),
        .reset       (reset),
        .count_cycle (busy && (cur_state != S_TRAP)),
        .count_instr (pc_write),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control: per-cycle expected state and
// control vector are queued as stimulus is applied, then checked mid-cycle.
module tb_mc_control;
    import riscv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, halt, zero, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        imem_req, ir_write, pc_write, pc_src, alu_src;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic [1:0]  alu_op;
    logic        busy, illegal, timeout;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instr_cnt;

    // Control vector bit weights, MSB first: imem_req .. timeout.
    localparam logic [13:0] C_IMEM = 14'h2000;
    localparam logic [13:0] C_IRW  = 14'h1000;
    localparam logic [13:0] C_PCW  = 14'h0800;
    localparam logic [13:0] C_PCS  = 14'h0400;
    localparam logic [13:0] C_ASRC = 14'h0200;
    localparam logic [13:0] C_MRD  = 14'h0100;
    localparam logic [13:0] C_MWR  = 14'h0080;
    localparam logic [13:0] C_M2R  = 14'h0040;
    localparam logic [13:0] C_RW   = 14'h0020;
    localparam logic [13:0] C_SUB  = 14'h0008;
    localparam logic [13:0] C_FN   = 14'h0010;
    localparam logic [13:0] C_BUSY = 14'h0004;
    localparam logic [13:0] C_ILL  = 14'h0002;
    localparam logic [13:0] C_TMO  = 14'h0001;

    typedef struct {
        logic [2:0]  st;
        logic [13:0] vec;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [13:0] obs_vec;
    assign obs_vec = {imem_req, ir_write, pc_write, pc_src, alu_src, mem_read,
                      mem_write, mem_to_reg, reg_write, alu_op, busy, illegal, timeout};

    mc_control #(.WAIT_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .busy       (busy),
        .illegal    (illegal),
        .timeout    (timeout),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [2:0] want_st, input logic [13:0] want_vec);
        checks++;
        assert (state === want_st) else begin
            errors++;
            $error("[TB] FAIL %s state got=%0d want=%0d", tag, state, want_st);
        end
        checks++;
        assert (obs_vec === want_vec) else begin
            errors++;
            $error("[TB] FAIL %s controls got=%014b want=%014b", tag, obs_vec, want_vec);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic check_output();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty got=0 want=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e.tag, e.st, e.vec);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, queue the expected
    // outputs, check at the falling edge, then advance past the next edge.
    task automatic apply_stimulus(input logic s, input logic h, input logic ir, input logic dr,
                                  input logic z, input state_t want_st, input logic [13:0] want_vec,
                                  input string tag);
        exp_t e;
        start = s; halt = h; imem_ready = ir; dmem_ready = dr; zero = z;
        e.st = want_st; e.vec = want_vec; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        apply_stimulus(1, 0, 1, 1, 0, S_IDLE, 14'h0, tag);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 0; halt = 0; zero = 0; imem_ready = 0; dmem_ready = 0;
        opcode = OP_R;

        apply_stimulus(1, 0, 1, 1, 0, S_IDLE, 14'h0, "reset_hold0");
        apply_stimulus(1, 0, 1, 1, 0, S_IDLE, 14'h0, "reset_hold1");
        check_cnt("reset_cycle_cnt", cycle_cnt, 32'd0);
        reset = 1'b1;

        // R-type with halt pending at the boundary: back to IDLE after WB.
        apply_stimulus(1, 0, 0, 0, 0, S_IDLE,   14'h0,                "r_idle");
        apply_stimulus(0, 0, 1, 0, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,  "r_fetch");
        apply_stimulus(0, 0, 1, 0, 0, S_DECODE, C_BUSY,               "r_decode");
        apply_stimulus(0, 1, 1, 0, 0, S_EXEC,   C_FN|C_BUSY,          "r_exec");
        apply_stimulus(0, 1, 1, 0, 0, S_WB,     C_RW|C_PCW|C_BUSY,    "r_wb");
        apply_stimulus(0, 0, 1, 0, 0, S_IDLE,   14'h0,                "halt_idle");
`ifdef MC_PERF_CNT_EN
        check_cnt("halt_instr_cnt", instr_cnt, 32'd1);
        check_cnt("halt_cycle_cnt", cycle_cnt, 32'd4);
`else
        check_cnt("halt_instr_cnt", instr_cnt, 32'd0);
        check_cnt("halt_cycle_cnt", cycle_cnt, 32'd0);
`endif

        opcode = OP_I_ALU;
        apply_stimulus(1, 0, 0, 0, 0, S_IDLE,   14'h0,                     "i_idle");
        apply_stimulus(0, 0, 1, 0, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "i_fetch");
        apply_stimulus(0, 0, 1, 0, 0, S_DECODE, C_BUSY,                    "i_decode");
        apply_stimulus(0, 0, 1, 0, 0, S_EXEC,   C_ASRC|C_FN|C_BUSY,        "i_exec");
        apply_stimulus(0, 0, 1, 0, 0, S_WB,     C_RW|C_PCW|C_BUSY,         "i_wb");

        opcode = OP_BRANCH;
        apply_stimulus(0, 0, 1, 0, 1, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "bz1_fetch");
        apply_stimulus(0, 0, 1, 0, 1, S_DECODE, C_BUSY,                    "bz1_decode");
        apply_stimulus(0, 0, 1, 0, 1, S_EXEC,   C_PCW|C_PCS|C_SUB|C_BUSY,  "bz1_exec");
        apply_stimulus(0, 0, 1, 0, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "bz0_fetch");
        apply_stimulus(0, 0, 1, 0, 0, S_DECODE, C_BUSY,                    "bz0_decode");
        apply_stimulus(0, 0, 1, 0, 0, S_EXEC,   C_PCW|C_SUB|C_BUSY,        "bz0_exec");

        opcode = OP_STORE;
        apply_stimulus(0, 0, 1, 1, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "st_fetch");
        apply_stimulus(0, 0, 1, 1, 0, S_DECODE, C_BUSY,                    "st_decode");
        apply_stimulus(0, 0, 1, 1, 0, S_EXEC,   C_ASRC|C_BUSY,             "st_exec");
        apply_stimulus(0, 0, 1, 1, 0, S_MEM,    C_ASRC|C_MWR|C_PCW|C_BUSY, "st_mem");

        opcode = OP_LOAD;
        apply_stimulus(0, 0, 1, 0, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "ld_fetch");
        apply_stimulus(0, 0, 1, 0, 0, S_DECODE, C_BUSY,                    "ld_decode");
        apply_stimulus(0, 0, 1, 0, 0, S_EXEC,   C_ASRC|C_BUSY,             "ld_exec");
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 0, 1, 0, 0, S_MEM, C_ASRC|C_MRD|C_BUSY,      "ld_mem_wait");
        apply_stimulus(0, 0, 1, 1, 0, S_MEM,    C_ASRC|C_MRD|C_BUSY,       "ld_mem_ready");
        apply_stimulus(0, 0, 1, 0, 0, S_WB,     C_RW|C_M2R|C_PCW|C_BUSY,   "ld_wb");

        // Fetch ready arrives in the last allowed wait cycle and must win.
        opcode = OP_R;
        for (int i = 0; i < 14; i++)
            apply_stimulus(0, 0, 0, 0, 0, S_FETCH, C_IMEM|C_BUSY,          "lim_fetch_wait");
        apply_stimulus(0, 0, 1, 0, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "lim_fetch_ready");
        apply_stimulus(0, 0, 1, 0, 0, S_DECODE, C_BUSY,                    "lim_decode");
        apply_stimulus(0, 1, 1, 0, 0, S_EXEC,   C_FN|C_BUSY,               "lim_exec");
        apply_stimulus(0, 1, 1, 0, 0, S_WB,     C_RW|C_PCW|C_BUSY,         "lim_wb");
        apply_stimulus(0, 0, 1, 0, 0, S_IDLE,   14'h0,                     "lim_idle");

        opcode = 7'b1111111;
        apply_stimulus(1, 0, 1, 1, 0, S_IDLE,   14'h0,                     "ill_idle");
        apply_stimulus(1, 0, 1, 1, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "ill_fetch");
        apply_stimulus(1, 0, 1, 1, 0, S_DECODE, C_BUSY,                    "ill_decode");
        for (int i = 0; i < 3; i++)
            apply_stimulus(1, 0, 1, 1, 0, S_TRAP, C_BUSY|C_ILL,            "ill_trap");
        pulse_reset("ill_reset");

        opcode = OP_R;
        apply_stimulus(1, 0, 0, 0, 0, S_IDLE,   14'h0,                     "tmo_idle");
        for (int i = 0; i < 15; i++)
            apply_stimulus(0, 0, 0, 0, 0, S_FETCH, C_IMEM|C_BUSY,          "tmo_fetch_wait");
        apply_stimulus(0, 0, 1, 1, 0, S_TRAP,   C_BUSY|C_TMO,              "tmo_trap0");
        apply_stimulus(1, 0, 1, 1, 0, S_TRAP,   C_BUSY|C_TMO,              "tmo_trap1");
        pulse_reset("tmo_reset");

        // Asynchronous reset in the middle of a data-memory wait.
        opcode = OP_LOAD;
        apply_stimulus(1, 0, 0, 0, 0, S_IDLE,   14'h0,                     "mr_idle");
        apply_stimulus(0, 0, 1, 0, 0, S_FETCH,  C_IMEM|C_IRW|C_BUSY,       "mr_fetch");
        apply_stimulus(0, 0, 1, 0, 0, S_DECODE, C_BUSY,                    "mr_decode");
        apply_stimulus(0, 0, 1, 0, 0, S_EXEC,   C_ASRC|C_BUSY,             "mr_exec");
        apply_stimulus(0, 0, 1, 0, 0, S_MEM,    C_ASRC|C_MRD|C_BUSY,       "mr_mem");
        #2 reset = 1'b0;
        #1 compare("mr_async", S_IDLE, 14'h0);
        check_cnt("mr_cycle_cnt", cycle_cnt, 32'd0);
        check_cnt("mr_instr_cnt", instr_cnt, 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(0, 0, 1, 1, 0, S_IDLE,   14'h0,                     "mr_hold");
        reset = 1'b1;
        apply_stimulus(0, 0, 1, 1, 0, S_IDLE,   14'h0,                     "mr_release");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
